// File: rtl/sum_avg_buffer.sv
// sum_avg_buffer
// Buffers 10-bit group sums from the accumulator in a small first-word-fall-through
// FIFO and presents each head entry as an 8-bit average (sum / 4) to the sink.
// Also keeps a 16-bit wrapping count of words delivered on port b, for debug.
//
// Optional build macro:
//   SUM_AVG_ROUND_EN  defined   -> data_out = (sum + 2) >> 2  (round half up)
//                     undefined -> data_out = sum >> 2        (truncate)
//
// ready_a depends only on buffer state. A full buffer therefore refuses a new
// word even in a cycle where the sink is reading; it accepts on the next cycle.

module sum_avg_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_a,
    output logic                     ready_a,
    input  logic [DW-1:0]            data_in,
    output logic                     valid_b,
    input  logic                     ready_b,
    output logic [7:0]               data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              out_cnt
);

    localparam int AW = $clog2(DEPTH);

`ifdef SUM_AVG_ROUND_EN
    localparam logic [DW:0] RND = (DW+1)'(2);
`else
    localparam logic [DW:0] RND = '0;
`endif

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr;
    logic          rd;
    logic [DW:0]   sum_ext;
    logic [DW:0]   avg_full;
    logic          unused_bits;

    // Pointer-derived status: the extra MSB distinguishes full from empty.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign ready_a = !full;
    assign valid_b = !empty;
    assign wr      = valid_a && ready_a;
    assign rd      = valid_b && ready_b;

    // Head entry average; a sum of 1020 yields 255 in both modes, so no saturation.
    always_comb begin
        sum_ext     = {1'b0, mem[rd_ptr[AW-1:0]]} + RND;
        avg_full    = sum_ext >> 2;
        data_out    = empty ? 8'd0 : avg_full[7:0];
        unused_bits = ^avg_full[DW:8];
    end

    // Storage array: no reset, stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // Pointers, occupancy and delivered-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_cnt <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                out_cnt <= out_cnt + 16'd1;
            end
            if (wr && !rd) begin
                count <= count + PTR_ONE;
            end else if (rd && !wr) begin
                count <= count - PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sum_avg_buffer.sv
// Scoreboard bench for sum_avg_buffer. Accepted writes push their hand-computed
// average into a queue; a monitor pops and compares on every port-b handshake.
// Expectations follow SUM_AVG_ROUND_EN when it is defined for the build.

module tb_sum_avg_buffer;

    logic        clk;
    logic        rst_n;
    logic        valid_a;
    logic        ready_a;
    logic [9:0]  data_in;
    logic        valid_b;
    logic        ready_b;
    logic [7:0]  data_out;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] out_cnt;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    sum_avg_buffer #(.DEPTH(4), .DW(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_a  (valid_a),
        .ready_a  (ready_a),
        .data_in  (data_in),
        .valid_b  (valid_b),
        .ready_b  (ready_b),
        .data_out (data_out),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .out_cnt  (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every handshake on port b must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && valid_b && ready_b) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %0d, expected no output", data_out);
            end else begin
                chk("data_out", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    // Offer one word; expected average is queued at the handshake. Returns at posedge+1.
    task automatic send(input logic [9:0] s, input logic [7:0] e);
        bit ok;
        ok = 1'b0;
        valid_a = 1'b1;
        data_in = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_a) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (ok) begin
            exp_q.push_back(e);
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready_a stayed 0 for sum %0d", s);
        end
        @(posedge clk);
        #1 valid_a = 1'b0;
    endtask

    task automatic wait_empty();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (empty) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain_timeout: empty stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    // Reset applied away from the clock edges; returns at posedge+1.
    task automatic do_reset();
        valid_a = 1'b0;
        ready_b = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_a = 1'b0;
        ready_b = 1'b0;
        data_in = '0;
        #1;
        do_reset();

        // Reset then idle
        chk("rst_ready_a", ready_a, 1);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_out_cnt", out_cnt, 0);

        // Single word with sink ready
        ready_b = 1'b1;
`ifdef SUM_AVG_ROUND_EN
        send(10'd102, 8'd26);
        chk("single_data_out", data_out, 26);
`else
        send(10'd102, 8'd25);
        chk("single_data_out", data_out, 25);
`endif
        chk("single_valid_b", valid_b, 1);
        @(posedge clk);
        #1;
        chk("single_empty", empty, 1);
        chk("single_out_cnt", out_cnt, 1);

        // Fill with sink stalled, then refuse a fifth word while full
        do_reset();
        send(10'd4, 8'd1);
        send(10'd8, 8'd2);
        chk("stall_data_held", data_out, 1);
        send(10'd12, 8'd3);
        send(10'd16, 8'd4);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        chk("fill_ready_a", ready_a, 0);
        valid_a = 1'b1;
        data_in = 10'd20;
        @(posedge clk);
        #1;
        chk("full_refuse_count", count, 4);
        ready_b = 1'b1;
        @(posedge clk);
        #1;
        ready_b = 1'b0;
        chk("after_read_count", count, 3);
        chk("after_read_ready_a", ready_a, 1);
        exp_q.push_back(8'd5);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        chk("refill_count", count, 4);
        chk("refill_full", full, 1);
        ready_b = 1'b1;
        wait_empty();
        chk("fill_out_cnt", out_cnt, 5);

        // Pointer wrap with alternating sink readiness
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(10'(i * 4), 8'(i));
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1 ready_b = ~ready_b;
                end
            end
        join
        ready_b = 1'b1;
        wait_empty();
        chk("wrap_out_cnt", out_cnt, 10);
        chk("wrap_queue_left", exp_q.size(), 0);

        // Boundary sums
        do_reset();
        ready_b = 1'b1;
`ifdef SUM_AVG_ROUND_EN
        send(10'd1020, 8'd255);
        send(10'd0,    8'd0);
        send(10'd1,    8'd0);
        send(10'd3,    8'd1);
`else
        send(10'd1020, 8'd255);
        send(10'd0,    8'd0);
        send(10'd1,    8'd0);
        send(10'd3,    8'd0);
`endif
        wait_empty();
        chk("bound_out_cnt", out_cnt, 4);

        // Asynchronous reset with three entries held
        do_reset();
        send(10'd40, 8'd10);
        send(10'd44, 8'd11);
        send(10'd48, 8'd12);
        chk("mid_count", count, 3);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_ready_a", ready_a, 1);
        chk("async_valid_b", valid_b, 0);
        chk("async_data_out", data_out, 0);
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        chk("async_full", full, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_b = 1'b1;
        send(10'd400, 8'd100);
        wait_empty();
        chk("post_rst_out_cnt", out_cnt, 1);
        chk("post_rst_queue_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
